remote_boot_request: RTL and testbench
======================================

// Module: remote_boot_request
// PURPOSE
//  Upstream stage of the factory-image remote-update FSM; sole driver of its bootapp level.
//  Qualifies host reboot commands (from the protocol-1 command decoder) with an ARM/BOOT pair
//  and a timeout, and waits until flash activity is idle. After a hold-off that lets the Ethernet
//  reply drain, it asserts bootapp. Prevents a single corrupt packet from rebooting the radio.
// PARAMETERS
//  ARM_TIMEOUT  125_000_000  cycles ARMED may wait for CMD_BOOT before disarming (>=2)
//  TX_HOLDOFF   1_250_000    cycles flash_busy must stay low before bootapp asserts (>=1)
//  CMD_ARM      8'hA5        command code that arms
//  CMD_BOOT     8'h5A        command code that confirms the reboot
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  cmd_valid     in   1  one-cycle strobe; cmd_code valid in that cycle
//  cmd_code      in   8  command byte from the protocol decoder
//  flash_busy    in   1  high while EPCS erase/program/remote-update access is in progress
//  abort         in   1  level/pulse; cancels any pending request
//  bootapp       out  1  to the update FSM; sticky high once asserted, until reset
//  armed         out  1  high in ARMED
//  boot_pending  out  1  high in WAIT_IDLE or HOLDOFF
//  reject        out  1  one-cycle pulse: unexpected code in ARMED, or ARMED timeout
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all counters 0, all outputs 0.
//  All outputs are registered; each changes the cycle after the causing input.
//  States: IDLE, ARMED, WAIT_IDLE, HOLDOFF, BOOT.
//   IDLE: cmd_valid&&code==CMD_ARM -> ARMED; clear arm_cnt. Other codes are ignored, no reject.
//   ARMED: arm_cnt increments each cycle.
//     CMD_ARM: arm_cnt=0 (re-arm), stay in ARMED.
//     CMD_BOOT: -> WAIT_IDLE.
//     Any other code: -> IDLE, reject.
//     No cmd_valid and arm_cnt==ARM_TIMEOUT-1: -> IDLE, reject.
//   WAIT_IDLE: !flash_busy -> HOLDOFF with hold_cnt=0.
//   HOLDOFF: hold_cnt increments.
//     flash_busy=1: -> WAIT_IDLE (hold-off restarts from 0).
//     hold_cnt==TX_HOLDOFF-1 with flash_busy=0: -> BOOT.
//   BOOT: bootapp=1. Terminal; ignores cmd_valid and abort; only rst_n leaves.
//  Priorities (same cycle):
//   abort > cmd_valid > timeout.
//     abort in ARMED/WAIT_IDLE/HOLDOFF: -> IDLE, no reject.
//     abort in IDLE: no effect.
//   CMD_BOOT arriving in the timeout cycle is accepted.
//   cmd_valid during WAIT_IDLE/HOLDOFF is ignored.
//  Latency: CMD_BOOT with flash idle -> bootapp high after 1+1+TX_HOLDOFF clocks.
//  Counters: width $clog2(param+1), unsigned. Never wrap, because each reload or exit happens
//  at terminal count.
//  Reset mid-operation: immediate return to IDLE, bootapp drops (downstream FSM is also reset).
//  Illegal state encoding: -> IDLE.
// STRUCTURE
//  Package remote_boot_pkg: state enum (boot_state_t), default CMD_ARM/CMD_BOOT localparams.
//  Sub-module cycle_timer (clear, enable, terminal-count flag, parameter N).
//  Instantiated twice: arm timeout and hold-off.
//  Top holds the FSM and the output registers only.
// TESTING
//  Use ARM_TIMEOUT=16, TX_HOLDOFF=8 in sim.
//  1 A5 then 5A, flash_busy=0 -> armed 1 clk after A5; boot_pending 1 clk after 5A;
//    bootapp high exactly 10 clks after the 5A strobe and stays high.
//  2 A5, then nothing for 16 clks -> reject pulse once; armed low; bootapp never rises.
//  3 A5, then 0x33 -> reject, IDLE; a following 5A alone is ignored (bootapp=0).
//  4 A5, 5A with flash_busy=1 for 20 clks, then a busy glitch at hold_cnt=5
//    -> bootapp asserts 8 clks after the final busy deassert.
//  5 abort and 5A strobe in the same cycle in ARMED -> IDLE, no reject;
//    abort in BOOT -> bootapp stays 1.
//  6 rst_n low mid-HOLDOFF -> all outputs 0 asynchronously; after release the full sequence
//    works again.

Source files
------------

// File: rtl/remote_boot_pkg.sv
// Shared types and defaults for the remote boot request stage.
// Imported by the top-level FSM and its cycle timers.
package remote_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_HOLDOFF   = 3'd3,
        ST_BOOT      = 3'd4
    } boot_state_t;

    localparam logic [7:0] DEFAULT_CMD_ARM  = 8'hA5;
    localparam logic [7:0] DEFAULT_CMD_BOOT = 8'h5A;

    // Width of a counter that must hold values 0..n without wrapping.
    function automatic int unsigned count_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/remote_boot_request_cycle_timer.sv
// Clearable up-counter with a terminal-count flag at N-1.
// The count saturates at terminal so it can never wrap.
module cycle_timer
    import remote_boot_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned W = count_width(N);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == W'(N - 1));

endmodule

// File: rtl/remote_boot_request.sv
// Qualifies host reboot commands with an ARM/BOOT handshake and timeout, waits for
// flash to go idle for a hold-off window, then raises the sticky bootapp level.
module remote_boot_request
    import remote_boot_pkg::*;
#(
    parameter int unsigned ARM_TIMEOUT = 125_000_000,
    parameter int unsigned TX_HOLDOFF  = 1_250_000,
    parameter logic [7:0]  CMD_ARM     = DEFAULT_CMD_ARM,
    parameter logic [7:0]  CMD_BOOT    = DEFAULT_CMD_BOOT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_code,
    input  logic       flash_busy,
    input  logic       abort,
    output logic       bootapp,
    output logic       armed,
    output logic       boot_pending,
    output logic       reject
);

    boot_state_t state;
    boot_state_t state_next;
    logic        reject_next;

    logic        is_arm;
    logic        is_boot;
    logic        arm_clear;
    logic        arm_enable;
    logic        arm_tc;
    logic        hold_clear;
    logic        hold_enable;
    logic        hold_tc;

    assign is_arm  = cmd_valid && (cmd_code == CMD_ARM);
    assign is_boot = cmd_valid && (cmd_code == CMD_BOOT);

    // Timers restart on every entry into their state; a re-arm also restarts the arm timeout.
    assign arm_clear   = (state != ST_ARMED) || (!abort && is_arm);
    assign arm_enable  = (state == ST_ARMED);
    assign hold_clear  = (state != ST_HOLDOFF);
    assign hold_enable = (state == ST_HOLDOFF);

    cycle_timer #(
        .N(ARM_TIMEOUT)
    ) u_arm_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (arm_clear),
        .enable  (arm_enable),
        .terminal(arm_tc)
    );

    cycle_timer #(
        .N(TX_HOLDOFF)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hold_clear),
        .enable  (hold_enable),
        .terminal(hold_tc)
    );

    // Same-cycle priority is abort, then a command strobe, then the arm timeout.
    always_comb begin
        state_next  = state;
        reject_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_arm) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cmd_valid) begin
                    if (is_arm) begin
                        state_next = ST_ARMED;
                    end else if (is_boot) begin
                        state_next = ST_WAIT_IDLE;
                    end else begin
                        state_next  = ST_IDLE;
                        reject_next = 1'b1;
                    end
                end else if (arm_tc) begin
                    state_next  = ST_IDLE;
                    reject_next = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!flash_busy) begin
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (flash_busy) begin
                    state_next = ST_WAIT_IDLE;
                end else if (hold_tc) begin
                    state_next = ST_BOOT;
                end
            end
            ST_BOOT: begin
                state_next = ST_BOOT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            armed        <= 1'b0;
            boot_pending <= 1'b0;
            bootapp      <= 1'b0;
            reject       <= 1'b0;
        end else begin
            state        <= state_next;
            armed        <= (state_next == ST_ARMED);
            boot_pending <= (state_next == ST_WAIT_IDLE) || (state_next == ST_HOLDOFF);
            bootapp      <= (state_next == ST_BOOT);
            reject       <= reject_next;
        end
    end

endmodule

// File: tb/tb_remote_boot_request.sv
// Self-checking bench for remote_boot_request: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arm/boot handshake.
module tb_remote_boot_request;

    localparam int ARM_T = 16;
    localparam int HOLD  = 8;
    localparam logic [7:0] C_ARM  = 8'hA5;
    localparam logic [7:0] C_BOOT = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       flash_busy;
    logic       abort;
    logic       bootapp;
    logic       armed;
    logic       boot_pending;
    logic       reject;

    int assert_count = 0;
    int fail_count   = 0;

    // Model: armed / pending / booted flags plus ages counted in clocks.
    bit m_armed, m_pending, m_boot, m_reject;
    int arm_age;
    int quiet_run;

    remote_boot_request #(
        .ARM_TIMEOUT(ARM_T),
        .TX_HOLDOFF (HOLD),
        .CMD_ARM    (C_ARM),
        .CMD_BOOT   (C_BOOT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .flash_busy  (flash_busy),
        .abort       (abort),
        .bootapp     (bootapp),
        .armed       (armed),
        .boot_pending(boot_pending),
        .reject      (reject)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_armed   = 0;
        m_pending = 0;
        m_boot    = 0;
        m_reject  = 0;
        arm_age   = 0;
        quiet_run = 0;
    endtask

    // Boot fires once flash has been seen idle on HOLD+1 consecutive clocks after BOOT:
    // one clock to notice idle, then the full hold-off window.
    task automatic modelStep();
        m_reject = 0;
        if (m_boot) begin
        end else if (m_armed) begin
            if (abort) begin
                m_armed = 0;
            end else if (cmd_valid) begin
                if (cmd_code == C_ARM) begin
                    arm_age = 0;
                end else if (cmd_code == C_BOOT) begin
                    m_armed   = 0;
                    m_pending = 1;
                    quiet_run = 0;
                end else begin
                    m_armed  = 0;
                    m_reject = 1;
                end
            end else begin
                arm_age++;
                if (arm_age == ARM_T) begin
                    m_armed  = 0;
                    m_reject = 1;
                end
            end
        end else if (m_pending) begin
            if (abort) begin
                m_pending = 0;
            end else begin
                quiet_run = flash_busy ? 0 : quiet_run + 1;
                if (quiet_run == HOLD + 1) begin
                    m_pending = 0;
                    m_boot    = 1;
                end
            end
        end else if (cmd_valid && cmd_code == C_ARM) begin
            m_armed = 1;
            arm_age = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/armed"},   32'(armed),        32'(m_armed));
        checkOutput({tag, "/pending"}, 32'(boot_pending), 32'(m_pending));
        checkOutput({tag, "/bootapp"}, 32'(bootapp),      32'(m_boot));
        checkOutput({tag, "/reject"},  32'(reject),       32'(m_reject));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [7:0] code,
                                 input logic busy, input logic ab);
        @(negedge clk);
        cmd_valid  = v;
        cmd_code   = code;
        flash_busy = busy;
        abort      = ab;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic idleCycles(input string tag, input int n, input logic busy);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 8'h00, busy, 1'b0);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkAll(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int lat;
    int rej_seen;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_code   = 8'h00;
        flash_busy = 1'b0;
        abort      = 1'b0;
        modelReset();
        #1;
        checkAll("reset_async");
        doReset("reset");

        // 1: clean ARM/BOOT; latency counted with the strobe cycle as clock one.
        applyStimulus("s1_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        checkOutput("s1_armed_next", 32'(armed), 32'd1);
        applyStimulus("s1_boot", 1'b1, C_BOOT, 1'b0, 1'b0);
        checkOutput("s1_pending_next", 32'(boot_pending), 32'd1);
        lat = 1;
        while (!bootapp && lat < 40) begin
            applyStimulus("s1_wait", 1'b0, 8'h00, 1'b0, 1'b0);
            lat++;
        end
        checkOutput("s1_latency", 32'(lat), 32'(1 + 1 + HOLD));
        idleCycles("s1_sticky", 5, 1'b0);
        checkOutput("s1_bootapp_sticky", 32'(bootapp), 32'd1);

        // 2: arm timeout.
        doReset("s2_reset");
        applyStimulus("s2_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        rej_seen = 0;
        for (int i = 0; i < ARM_T + 4; i++) begin
            applyStimulus("s2_wait", 1'b0, 8'h00, 1'b0, 1'b0);
            rej_seen += int'(reject);
        end
        checkOutput("s2_reject_count", 32'(rej_seen), 32'd1);
        checkOutput("s2_armed_low", 32'(armed), 32'd0);

        // 3: bad code while armed, then a lone BOOT is ignored.
        applyStimulus("s3_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s3_bad", 1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("s3_reject", 32'(reject), 32'd1);
        applyStimulus("s3_boot", 1'b1, C_BOOT, 1'b0, 1'b0);
        idleCycles("s3_idle", HOLD + 4, 1'b0);
        checkOutput("s3_no_boot", 32'(bootapp), 32'd0);

        // 4: busy flash, then a glitch at hold_cnt=5 restarts the hold-off.
        applyStimulus("s4_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s4_boot", 1'b1, C_BOOT, 1'b1, 1'b0);
        idleCycles("s4_busy", 20, 1'b1);
        idleCycles("s4_quiet", 6, 1'b0);
        applyStimulus("s4_glitch", 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("s4_release", 1'b0, 8'h00, 1'b0, 1'b0);
        lat = 0;
        while (!bootapp && lat < 40) begin
            applyStimulus("s4_wait", 1'b0, 8'h00, 1'b0, 1'b0);
            lat++;
        end
        checkOutput("s4_latency", 32'(lat), 32'(HOLD));

        // 5: abort beats a same-cycle BOOT; abort cannot undo BOOT.
        doReset("s5_reset");
        applyStimulus("s5_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s5_abort", 1'b1, C_BOOT, 1'b0, 1'b1);
        checkOutput("s5_no_reject", 32'(reject), 32'd0);
        checkOutput("s5_idle", 32'({armed, boot_pending}), 32'd0);
        applyStimulus("s5_arm2", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s5_boot", 1'b1, C_BOOT, 1'b0, 1'b0);
        idleCycles("s5_hold", HOLD + 2, 1'b0);
        applyStimulus("s5_late_abort", 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus("s5_late_abort2", 1'b1, C_ARM, 1'b0, 1'b1);
        checkOutput("s5_bootapp_kept", 32'(bootapp), 32'd1);

        // 6: asynchronous reset in HOLDOFF, then a full sequence again.
        doReset("s6_reset");
        applyStimulus("s6_arm", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s6_boot", 1'b1, C_BOOT, 1'b0, 1'b0);
        idleCycles("s6_hold", 4, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("s6_async_outputs", 32'({bootapp, armed, boot_pending, reject}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("s6_arm2", 1'b1, C_ARM, 1'b0, 1'b0);
        applyStimulus("s6_boot2", 1'b1, C_BOOT, 1'b0, 1'b0);
        idleCycles("s6_hold2", HOLD + 2, 1'b0);
        checkOutput("s6_bootapp_again", 32'(bootapp), 32'd1);

        // Randomized traffic with periodic resets so BOOT is not a dead end.
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic [7:0] code;
            logic       busy;
            logic       ab;
            int         pick;
            if (i % 150 == 0) doReset("rnd_reset");
            v    = ($urandom_range(0, 99) < 25);
            pick = int'($urandom_range(0, 9));
            code = (pick < 4) ? C_ARM : (pick < 8) ? C_BOOT : 8'($urandom);
            busy = ($urandom_range(0, 99) < 30);
            ab   = !v && ($urandom_range(0, 99) < 3);
            applyStimulus("rnd", v, code, busy, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
